// File: rtl/task_8_pkg.sv
// task_8_pkg: shared types and defaults for the task 8 datapath.
//   task_8_output_enum : transmit-stage packet state (idle / sending / draining last beat)
//   TASK_8_DATA_W      : default stream byte width
package task_8_pkg;

    localparam int unsigned TASK_8_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2
    } task_8_output_enum;

endpackage

// File: rtl/task_8_output_fifo.sv
// task_8_output_fifo: single-clock show-ahead FIFO.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears pointers)
//   wrreq, data    : write request and word; honoured when not full or when a pop
//                    happens in the same cycle
//   rdreq          : pop request; ignored when empty
//   q              : current head word, valid whenever empty is low
//   empty, full    : occupancy flags decoded from the pointers
module task_8_output_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             wrreq,
    input  logic             rdreq,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_rd = rdreq && !empty;
    assign do_wr = wrreq && (!full || do_rd);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign q     = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only words behind valid pointers are ever read.
    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= data;
    end

endmodule

// File: rtl/task_8_output.sv
// task_8_output: transmit stage of the task 8 datapath. Buffers core bytes in a
// FIFO as {last, data} words and replays them as an AXI-Stream master packet.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_data/i_enb/i_last: core byte, write strobe, end-of-packet marker
//   i_tready           : downstream ready
//   o_tvalid/o_tdata/o_tlast : registered stream outputs
//   o_busy             : packet in flight (S_SEND or S_DRAIN)
//   o_full, o_empty    : FIFO occupancy
//   o_overflow         : sticky, a write was dropped; cleared only by reset
// Build option TASK_8_OUTPUT_STORE_FWD_EN: when defined, a packet starts only
// once its last byte is buffered (store-and-forward); otherwise cut-through.
module task_8_output
    import task_8_pkg::*;
#(
    parameter int unsigned DATA_W = TASK_8_DATA_W,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_enb,
    input  logic              i_last,
    input  logic              i_tready,
    output logic              o_tvalid,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow
);

    task_8_output_enum state;
    logic [DATA_W:0]   head;
    logic              pop;
    logic              wr_accept;
    logic              eligible;

    // Load the output register from the FIFO head whenever the register is free
    // or being consumed this cycle; o_tvalid itself stays a pure flop output.
    assign pop       = (state == S_SEND) && !o_empty && (!o_tvalid || i_tready);
    assign wr_accept = i_enb && (!o_full || pop);

    task_8_output_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wrreq   (i_enb),
        .rdreq   (pop),
        .data    ({i_last, i_data}),
        .q       (head),
        .empty   (o_empty),
        .full    (o_full)
    );

`ifdef TASK_8_OUTPUT_STORE_FWD_EN
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Complete packets buffered but not yet loaded into the output register.
    logic [CW-1:0] pkt_cnt;
    logic          cnt_inc;
    logic          cnt_dec;

    assign cnt_inc  = wr_accept && i_last;
    assign cnt_dec  = pop && head[DATA_W];
    assign eligible = (pkt_cnt != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end
`else
    assign eligible = !o_empty;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (i_enb && !wr_accept) begin
            o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            o_busy   <= 1'b0;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
        end else begin
            if (pop) begin
                o_tvalid <= 1'b1;
                o_tdata  <= head[DATA_W-1:0];
                o_tlast  <= head[DATA_W];
            end else if (i_tready) begin
                o_tvalid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (eligible) begin
                        state  <= S_SEND;
                        o_busy <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (pop && head[DATA_W]) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (o_tvalid && i_tready) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_task_8_output.sv
// tb_task_8_output: self-checking bench for task_8_output (DATA_W 8, DEPTH 16).
// Expected {last, data} words are queued as bytes are written and popped on
// every stream handshake. Define TASK_8_OUTPUT_STORE_FWD_EN to exercise the
// store-and-forward build.
module tb_task_8_output;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_enb;
    logic       i_last;
    logic       i_tready;
    logic       o_tvalid;
    logic [7:0] o_tdata;
    logic       o_tlast;
    logic       o_busy;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;

    task_8_output #(
        .DATA_W (8),
        .DEPTH  (16)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_enb      (i_enb),
        .i_last     (i_last),
        .i_tready   (i_tready),
        .o_tvalid   (o_tvalid),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_busy     (o_busy),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [8:0]  sb [$];
    int unsigned beats = 0;
    int unsigned lasts = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshakes are evaluated on the falling edge, where inputs and outputs
    // are settled for the following rising edge.
    logic       prev_stall = 1'b0;
    logic       prev_lhs   = 1'b0;
    logic [8:0] prev_word  = '0;
    logic [8:0] mon_exp;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
            prev_lhs   = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(o_tvalid), 1);
                check_eq("stall_word", 32'({o_tlast, o_tdata}), 32'(prev_word));
            end
            if (prev_lhs) check_eq("pkt_gap_valid", 32'(o_tvalid), 0);
            prev_lhs = 1'b0;
            if (o_tvalid && i_tready) begin
                check_eq("beat_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    check_eq("beat_word", 32'({o_tlast, o_tdata}), 32'(mon_exp));
                end
                beats++;
                if (o_tlast) begin
                    lasts++;
                    prev_lhs = 1'b1;
                end
            end
            prev_stall = o_tvalid && !i_tready;
            prev_word  = {o_tlast, o_tdata};
        end
    end

    task automatic put_byte(input logic [7:0] d, input logic l, input bit keep);
        i_enb  = 1'b1;
        i_data = d;
        i_last = l;
        if (keep) sb.push_back({l, d});
        @(posedge i_clk);
        #1;
        i_enb  = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic wait_lasts(input int unsigned target, input int unsigned budget);
        for (int unsigned c = 0; c < budget; c++) begin
            if (lasts >= target) break;
            @(posedge i_clk);
            #1;
        end
    endtask

    int unsigned b0;
    int unsigned l0;
    int unsigned k;
    logic [3:0]  tpat;

    initial begin
        i_rst_n  = 1'b0;
        i_enb    = 1'b0;
        i_data   = '0;
        i_last   = 1'b0;
        i_tready = 1'b0;
        #2;
        check_eq("rst_tvalid",   32'(o_tvalid),   0);
        check_eq("rst_tdata",    32'(o_tdata),    0);
        check_eq("rst_tlast",    32'(o_tlast),    0);
        check_eq("rst_busy",     32'(o_busy),     0);
        check_eq("rst_full",     32'(o_full),     0);
        check_eq("rst_empty",    32'(o_empty),    1);
        check_eq("rst_overflow", 32'(o_overflow), 0);
        #20;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Single packet, tready held high.
        i_tready = 1'b1;
        b0 = beats;
        l0 = lasts;
`ifdef TASK_8_OUTPUT_STORE_FWD_EN
        put_byte(8'h11, 1'b0, 1'b1);
        put_byte(8'h22, 1'b0, 1'b1);
        put_byte(8'h33, 1'b0, 1'b1);
        check_eq("sf_hold_valid", 32'(o_tvalid), 0);
        put_byte(8'h44, 1'b1, 1'b1);
`else
        put_byte(8'h11, 1'b0, 1'b1);
        check_eq("lat_n1_empty", 32'(o_empty), 0);
        check_eq("lat_n1_valid", 32'(o_tvalid), 0);
        put_byte(8'h22, 1'b0, 1'b1);
        check_eq("lat_n2_busy", 32'(o_busy), 1);
        check_eq("lat_n2_valid", 32'(o_tvalid), 0);
        put_byte(8'h33, 1'b0, 1'b1);
        check_eq("lat_n3_valid", 32'(o_tvalid), 1);
        check_eq("lat_n3_data", 32'(o_tdata), 32'h11);
        put_byte(8'h44, 1'b1, 1'b1);
`endif
        wait_lasts(l0 + 1, 40);
        check_eq("p1_lasts", lasts - l0, 1);
        check_eq("p1_beats", beats - b0, 4);
        check_eq("p1_busy_after", 32'(o_busy), 0);

        // Backpressure: tready follows 1,0,0,1 while a 6-byte packet flows.
        tpat = 4'b1001;
        b0 = beats;
        l0 = lasts;
        k = 0;
        for (int c = 0; c < 80 && lasts < l0 + 1; c++) begin
            i_tready = tpat[c % 4];
            if (k < 6) begin
                i_enb  = 1'b1;
                i_data = 8'hC0 + 8'(k);
                i_last = (k == 5);
                sb.push_back({(k == 5), 8'hC0 + 8'(k)});
                k++;
            end else begin
                i_enb  = 1'b0;
                i_last = 1'b0;
            end
            @(posedge i_clk);
            #1;
        end
        i_enb  = 1'b0;
        i_last = 1'b0;
        check_eq("bp_beats", beats - b0, 6);
        check_eq("bp_lasts", lasts - l0, 1);

        // Back-to-back packets written contiguously.
        i_tready = 1'b1;
        b0 = beats;
        l0 = lasts;
        put_byte(8'h61, 1'b0, 1'b1);
        put_byte(8'h62, 1'b1, 1'b1);
        put_byte(8'h71, 1'b0, 1'b1);
        put_byte(8'h72, 1'b0, 1'b1);
        put_byte(8'h73, 1'b1, 1'b1);
        wait_lasts(l0 + 2, 60);
        check_eq("b2b_lasts", lasts - l0, 2);
        check_eq("b2b_beats", beats - b0, 5);

`ifdef TASK_8_OUTPUT_STORE_FWD_EN
        // Store-and-forward gating: nothing leaves until the last byte lands.
        repeat (3) @(posedge i_clk);
        #1;
        b0 = beats;
        l0 = lasts;
        put_byte(8'hE1, 1'b0, 1'b1);
        put_byte(8'hE2, 1'b0, 1'b1);
        put_byte(8'hE3, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            check_eq("sfg_wait_valid", 32'(o_tvalid), 0);
            @(posedge i_clk);
            #1;
        end
        put_byte(8'hE4, 1'b1, 1'b1);
        check_eq("sfg_n1_valid", 32'(o_tvalid), 0);
        @(posedge i_clk);
        #1;
        check_eq("sfg_n2_valid", 32'(o_tvalid), 0);
        @(posedge i_clk);
        #1;
        check_eq("sfg_n3_valid", 32'(o_tvalid), 1);
        wait_lasts(l0 + 1, 40);
        check_eq("sfg_beats", beats - b0, 4);
`endif

        // Overflow: park a 1-byte packet in the output register, then fill.
        repeat (3) @(posedge i_clk);
        #1;
        i_tready = 1'b0;
        b0 = beats;
        l0 = lasts;
        put_byte(8'hA0, 1'b1, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;
        check_eq("ovf_park_valid", 32'(o_tvalid), 1);
        check_eq("ovf_park_empty", 32'(o_empty), 1);
        for (int i = 0; i < 16; i++) begin
            put_byte(8'hB0 + 8'(i), (i == 15), 1'b1);
        end
        check_eq("ovf_full_16", 32'(o_full), 1);
        check_eq("ovf_flag_16", 32'(o_overflow), 0);
        put_byte(8'hCC, 1'b1, 1'b0);
        check_eq("ovf_full_17", 32'(o_full), 1);
        check_eq("ovf_flag_17", 32'(o_overflow), 1);
        i_tready = 1'b1;
        wait_lasts(l0 + 2, 80);
        check_eq("ovf_lasts", lasts - l0, 2);
        check_eq("ovf_beats", beats - b0, 17);
        check_eq("ovf_sticky", 32'(o_overflow), 1);
        check_eq("ovf_empty_after", 32'(o_empty), 1);

        // Reset asserted while beat 2 of 5 is on the bus.
        repeat (3) @(posedge i_clk);
        #1;
        i_tready = 1'b0;
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            put_byte(8'h81 + 8'(i), (i == 4), 1'b1);
        end
        i_tready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (beats - b0 >= 1) break;
            @(posedge i_clk);
            #1;
        end
        #1;
        check_eq("rmid_beats", beats - b0, 1);
        i_rst_n = 1'b0;
        #1;
        check_eq("rmid_valid",    32'(o_tvalid),   0);
        check_eq("rmid_busy",     32'(o_busy),     0);
        check_eq("rmid_empty",    32'(o_empty),    1);
        check_eq("rmid_overflow", 32'(o_overflow), 0);
        sb.delete();
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        b0 = beats;
        l0 = lasts;
        put_byte(8'h91, 1'b0, 1'b1);
        put_byte(8'h92, 1'b0, 1'b1);
        put_byte(8'h93, 1'b1, 1'b1);
        wait_lasts(l0 + 1, 40);
        check_eq("rpost_lasts", lasts - l0, 1);
        check_eq("rpost_beats", beats - b0, 3);

        repeat (3) @(posedge i_clk);
        #1;
        check_eq("sb_drained", 32'(sb.size()), 0);
        check_eq("end_busy", 32'(o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/task_8_output.md
# task_8_output

Transmit stage of the task 8 datapath, the counterpart of the AXI-Stream receive stage. It collects processed bytes from the core, strobed by `i_enb` and delimited by `i_last`, into an internal FIFO, and replays them as an AXI-Stream master packet. The stream carries `o_tvalid`, `o_tdata` and `o_tlast`, and honours downstream `i_tready`. It sits between the processing core and the board-level stream sink.

## Interface
- `DATA_W`, default 8: byte width of the stream.
- `DEPTH`, default 16: FIFO depth in words; must be a power of two, minimum 4.
- `i_clk`, in, 1: single clock; all logic on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_data`, in, `DATA_W`: processed byte from the core.
- `i_enb`, in, 1: write strobe; `i_data` and `i_last` are sampled when high.
- `i_last`, in, 1: marks the final byte of a packet; qualified by `i_enb`.
- `i_tready`, in, 1: downstream ready.
- `o_tvalid`, out, 1: stream valid.
- `o_tdata`, out, `DATA_W`: stream data.
- `o_tlast`, out, 1: stream last.
- `o_busy`, out, 1: high while a packet is being transmitted.
- `o_full`, out, 1: FIFO full.
- `o_empty`, out, 1: FIFO empty.
- `o_overflow`, out, 1: sticky; a write was dropped. Cleared only by reset.

## Operation
- The FIFO word is {last, data}, `DATA_W+1` bits wide. The FIFO is synchronous and single-clock.
- **Write path:**
  - The FIFO writes when `i_enb` is high and either the FIFO is not full or a pop happens in the same cycle.
  - When full and there is no pop, the byte is dropped and `o_overflow` sets.
- **Packet counter `pkt_cnt`, width clog2(`DEPTH`)+1:**
  - +1 on an accepted write with `i_last` set.
  - −1 when the output register loads a word with last set.
  - Both in the same cycle: unchanged.
- **Output register:**
  - `o_tdata`, `o_tlast` and `o_tvalid` are registered.
  - The register loads the FIFO head (a pop) when (`!o_tvalid || i_tready`), the FIFO is not empty, and the state is S_SEND.
  - `o_tvalid`, `o_tdata` and `o_tlast` hold steady while `o_tvalid && !i_tready` (AXI rule; no combinational path from `i_tready` to `o_tvalid`).
- **State machine:**
  - S_IDLE: on `eligible` → S_SEND.
  - S_SEND: pops as above. Loading a word with last set → S_DRAIN.
  - S_DRAIN: popping is stopped. On `o_tvalid && i_tready` → S_IDLE.
- **`o_busy`:** high in S_SEND and S_DRAIN.
- **Packets:** are never interleaved. A packet longer than `DEPTH` is only supported in cut-through mode.
- **Reset values:** every output is 0 except `o_empty`, which is 1. State S_IDLE, `pkt_cnt` 0, FIFO pointers 0. An assertion mid-packet discards all buffered data immediately, and `o_tvalid` drops asynchronously.

## Timing
- **Cut-through latency:** `i_enb` at cycle N into an empty, idle block gives `o_tvalid` = 1 at N+3 (FIFO write N+1, state S_SEND N+2, load N+3).
- **Store-and-forward latency:** the count is taken from the byte carrying `i_last`. That byte written at N gives `pkt_cnt` = 1 at N+1 and `o_tvalid` at N+3.
- **Throughput:** one beat per cycle while `i_tready` = 1 and data is eligible.
- **Packet gaps:** a minimum of one idle cycle between packets (S_DRAIN → S_IDLE → S_SEND). `o_tvalid` may also drop inside a packet when the FIFO runs empty in cut-through mode.
- **Full boundary:** write plus pop in the same cycle at full is accepted; count unchanged, `o_full` stays 1.
- **Empty boundary:** write into an empty FIFO clears `o_empty` the next cycle. There is no same-cycle bypass.

## Configuration
- `TASK_8_OUTPUT_STORE_FWD_EN`
  - Defined: store-and-forward. `eligible` = (`pkt_cnt` != 0), so a packet starts only once its last byte is buffered and `o_tvalid` never drops mid-packet. A packet longer than `DEPTH` deadlocks by design, and the bench must not do it.
  - Undefined: cut-through. `eligible` = !`o_empty`, and `pkt_cnt` logic is not synthesised.

## Structure
- Package `task_8_pkg`:
  - typedef enum `task_8_output_enum` {S_IDLE, S_SEND, S_DRAIN}
  - localparam `TASK_8_DATA_W` = 8, which is the default source for `DATA_W`.
- Sub-module `task_8_output_fifo`:
  - Parameterised width and depth, asynchronous active-low reset.
  - Ports: wrreq, rdreq, data, q, empty, full.
  - The head word is presented on q (show-ahead), so a pop and a load happen in the same cycle.

## Test plan
- **Single packet:** 4 bytes 0x11,0x22,0x33,0x44 with `i_last` on 0x44, `i_tready` = 1 → identical bytes on `o_tdata`, `o_tlast` only on 0x44, `o_busy` falls one cycle after the last handshake.
- **Backpressure:** `i_tready` toggling 1,0,0,1 during a 6-byte packet → `o_tdata` and `o_tvalid` stable through stalls, 6 handshakes, order preserved.
- **Overflow:** 17 writes with `DEPTH` = 16 and `i_tready` = 0 → `o_full` = 1 after the 16th, 17th dropped, `o_overflow` = 1 and sticky.
- **Store-forward gating** (macro on): 3 bytes without last → `o_tvalid` stays 0. Fourth byte with last → `o_tvalid` 2 cycles later, 4 beats.
- **Back-to-back packets:** 2-byte then 3-byte packet written contiguously → two `o_tlast` pulses, at least one idle cycle between packets.
- **Reset mid-packet:** `i_rst_n` low during beat 2 of 5 → `o_tvalid`, `o_busy` = 0 and `o_empty` = 1 immediately; after release a new packet transmits correctly.
